// File: rtl/frame_rx_deframer_if.sv
// frame_rx_deframer_if: bus bundle between the serial line side and the
// deframer. The master modport is the line/consumer side (drives rx_bit and
// abort, observes results); the slave modport is the deframer itself.
interface frame_rx_deframer_if #(
    parameter int CNT_W = 8
) ();
    logic             rx_bit;
    logic             abort;
    logic [15:0]      rx_frame;
    logic             frame_rx_valid;
    logic             rx_busy;
    logic [CNT_W-1:0] rx_ok_count;
    logic [CNT_W-1:0] rx_drop_count;

    modport master (
        output rx_bit,
        output abort,
        input  rx_frame,
        input  frame_rx_valid,
        input  rx_busy,
        input  rx_ok_count,
        input  rx_drop_count
    );

    modport slave (
        input  rx_bit,
        input  abort,
        output rx_frame,
        output frame_rx_valid,
        output rx_busy,
        output rx_ok_count,
        output rx_drop_count
    );
endinterface

// File: rtl/frame_rx_deframer.sv
// frame_rx_deframer: hunts a 1-bit-per-clock line for the 4-bit SFD,
// deserializes the 12 body bits {DST, SRC, PAYLOAD}, filters on destination
// address and presents accepted frames with a one-cycle valid pulse.
// Optional feature macro: RX_BROADCAST_EN (also accept DST==4'hF).
module frame_rx_deframer #(
    parameter logic [3:0] MAC_ADDRESS = 4'hA,
    parameter logic [3:0] SFD         = 4'b0101,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    frame_rx_deframer_if.slave bus
);

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [3:0]       sfd_sr_q,    sfd_sr_d;
    logic [3:0]       bit_cnt_q,   bit_cnt_d;
    logic [10:0]      body_q,      body_d;
    logic [15:0]      rx_frame_q,  rx_frame_d;
    logic             valid_q,     valid_d;
    logic [CNT_W-1:0] ok_cnt_q,    ok_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

    logic [11:0]      body12;
    logic [3:0]       dst;
    logic [3:0]       src;
    logic             dst_ok;
    logic             accept;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Completed body as it stands when the 12th body bit is on the line.
    assign body12 = {body_q, bus.rx_bit};
    assign dst    = body12[11:8];
    assign src    = body12[7:4];

`ifdef RX_BROADCAST_EN
    assign dst_ok = (dst == MAC_ADDRESS) || (dst == 4'hF);
`else
    assign dst_ok = (dst == MAC_ADDRESS);
`endif

    // Loopback frames (our own SRC) are never accepted.
    assign accept = dst_ok && (src != MAC_ADDRESS);

    // Next-state logic: SFD hunt, body shift, filter decision and abort flush.
    always_comb begin
        state_d    = state_q;
        sfd_sr_d   = sfd_sr_q;
        bit_cnt_d  = bit_cnt_q;
        body_d     = body_q;
        rx_frame_d = rx_frame_q;
        valid_d    = 1'b0;
        ok_cnt_d   = ok_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (bus.abort) begin
            // Flush any partial frame; the last accepted frame and stats stay.
            state_d   = ST_HUNT;
            sfd_sr_d  = 4'b0000;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    sfd_sr_d = {sfd_sr_q[2:0], bus.rx_bit};
                    if ({sfd_sr_q[2:0], bus.rx_bit} == SFD) begin
                        state_d   = ST_RECV;
                        bit_cnt_d = 4'd0;
                        body_d    = 11'd0;
                    end
                end
                ST_RECV: begin
                    body_d    = {body_q[9:0], bus.rx_bit};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd11) begin
                        // Frame complete; hunting restarts from a clean shifter
                        // so frame bits can never be mistaken for an SFD.
                        state_d   = ST_HUNT;
                        sfd_sr_d  = 4'b0000;
                        bit_cnt_d = 4'd0;
                        if (accept) begin
                            rx_frame_d = {SFD, body12};
                            valid_d    = 1'b1;
                            ok_cnt_d   = sat_inc(ok_cnt_q);
                        end else begin
                            drop_cnt_d = sat_inc(drop_cnt_q);
                        end
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    sfd_sr_d  = 4'b0000;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Control, result and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            sfd_sr_q   <= 4'b0000;
            bit_cnt_q  <= 4'd0;
            rx_frame_q <= 16'h0000;
            valid_q    <= 1'b0;
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sfd_sr_q   <= sfd_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_frame_q <= rx_frame_d;
            valid_q    <= valid_d;
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Body shifter is pure datapath; it is cleared on every SFD match.
    always_ff @(posedge clk) begin
        body_q <= body_d;
    end

    assign bus.rx_frame       = rx_frame_q;
    assign bus.frame_rx_valid = valid_q;
    assign bus.rx_busy        = (state_q == ST_RECV);
    assign bus.rx_ok_count    = ok_cnt_q;
    assign bus.rx_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_frame_rx_deframer.sv
// Testbench for frame_rx_deframer (MAC_ADDRESS=4'hB, CNT_W=8). Accepted
// frames are queued when driven and checked by a negedge monitor.
module tb_frame_rx_deframer;

    logic clk;
    logic rst;

    frame_rx_deframer_if #(.CNT_W(8)) bus ();

    frame_rx_deframer #(
        .MAC_ADDRESS(4'hB),
        .SFD        (4'b0101),
        .CNT_W      (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] exp_q[$];
    int          vld_cyc_q[$];
    logic [7:0]  exp_ok;
    logic [7:0]  exp_drop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (bus.frame_rx_valid === 1'b1) begin
            checks++;
            vld_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid rx_frame=%h (no frame expected)", bus.rx_frame);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.rx_frame !== e) begin
                    errors++;
                    $display("FAIL scoreboard_frame got=%h exp=%h", bus.rx_frame, e);
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        bus.rx_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0);
    endtask

    task automatic send_frame(input logic [15:0] f, input bit acc);
        if (acc) begin
            exp_q.push_back(f);
            if (exp_ok != 8'hFF) exp_ok = exp_ok + 8'd1;
        end else begin
            if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
        end
        for (int i = 15; i >= 0; i--) drive_bit(f[i]);
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (bus.rx_ok_count !== exp_ok) begin
            errors++;
            $display("FAIL %s_ok_count got=%0d exp=%0d", name, bus.rx_ok_count, exp_ok);
        end
        checks++;
        if (bus.rx_drop_count !== exp_drop) begin
            errors++;
            $display("FAIL %s_drop_count got=%0d exp=%0d", name, bus.rx_drop_count, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_bit = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ok = 8'd0;
        exp_drop = 8'd0;
        checks++;
        if (bus.rx_frame !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rx_frame got=%h exp=0000", bus.rx_frame);
        end
        checks++;
        if (bus.frame_rx_valid !== 1'b0 || bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags valid=%b busy=%b exp 0/0", bus.frame_rx_valid, bus.rx_busy);
        end
        check_counts("reset");
    endtask

    task automatic test_accept();
        logic [15:0] f;
        f = 16'h5BA7;
        idle(5);
        exp_q.push_back(f);
        exp_ok = exp_ok + 8'd1;
        for (int i = 15; i >= 1; i--) drive_bit(f[i]);
        checks++;
        if (bus.frame_rx_valid !== 1'b0 || bus.rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_before_last valid=%b busy=%b exp 0/1", bus.frame_rx_valid, bus.rx_busy);
        end
        drive_bit(f[0]);
        checks++;
        if (bus.frame_rx_valid !== 1'b1 || bus.rx_frame !== 16'h5BA7) begin
            errors++;
            $display("FAIL accept_latency valid=%b frame=%h exp 1/5ba7", bus.frame_rx_valid, bus.rx_frame);
        end
        checks++;
        if (bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_busy_after got=%b exp=0", bus.rx_busy);
        end
        check_counts("accept");
        drive_bit(1'b0);
        checks++;
        if (bus.frame_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_pulse_width valid=%b exp=0", bus.frame_rx_valid);
        end
    endtask

    task automatic test_filter();
        send_frame(16'h5CA7, 1'b0);
        send_frame(16'h5BB3, 1'b0);
        idle(2);
        checks++;
        if (bus.rx_frame !== 16'h5BA7) begin
            errors++;
            $display("FAIL filter_frame_held got=%h exp=5ba7", bus.rx_frame);
        end
        check_counts("filter");
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = vld_cyc_q.size();
        send_frame(16'h5BA1, 1'b1);
        send_frame(16'h5BD2, 1'b1);
        idle(2);
        checks++;
        if (vld_cyc_q.size() != n0 + 2) begin
            errors++;
            $display("FAIL b2b_pulse_count got=%0d exp=2", vld_cyc_q.size() - n0);
        end else begin
            checks++;
            if (vld_cyc_q[n0+1] - vld_cyc_q[n0] != 16) begin
                errors++;
                $display("FAIL b2b_spacing got=%0d exp=16", vld_cyc_q[n0+1] - vld_cyc_q[n0]);
            end
        end
        checks++;
        if (bus.rx_frame !== 16'h5BD2) begin
            errors++;
            $display("FAIL b2b_last_frame got=%h exp=5bd2", bus.rx_frame);
        end
        check_counts("b2b");
    endtask

    task automatic test_abort();
        logic [15:0] f;
        f = 16'h5BC4;
        // SFD plus five body bits, abort together with body bit 6
        for (int i = 15; i >= 7; i--) drive_bit(f[i]);
        bus.abort = 1'b1;
        drive_bit(f[6]);
        bus.abort = 1'b0;
        checks++;
        if (bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got=%b exp=0", bus.rx_busy);
        end
        idle(3);
        send_frame(16'h5BA9, 1'b1);
        idle(2);
        check_counts("abort");
        // abort coinciding with the final body bit discards the frame
        f = 16'h5BA5;
        for (int i = 15; i >= 1; i--) drive_bit(f[i]);
        bus.abort = 1'b1;
        drive_bit(f[0]);
        bus.abort = 1'b0;
        checks++;
        if (bus.frame_rx_valid !== 1'b0 || bus.rx_frame !== 16'h5BA9) begin
            errors++;
            $display("FAIL abort_last_bit valid=%b frame=%h exp 0/5ba9", bus.frame_rx_valid, bus.rx_frame);
        end
        idle(2);
        check_counts("abort_last");
    endtask

    task automatic test_rst_mid();
        logic [15:0] f;
        f = 16'h5BC4;
        for (int i = 15; i >= 7; i--) drive_bit(f[i]);
        rst = 1'b1;
        drive_bit(f[6]);
        rst = 1'b0;
        exp_ok = 8'd0;
        exp_drop = 8'd0;
        checks++;
        if (bus.rx_frame !== 16'h0000 || bus.frame_rx_valid !== 1'b0 || bus.rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs frame=%h valid=%b busy=%b exp 0000/0/0",
                     bus.rx_frame, bus.frame_rx_valid, bus.rx_busy);
        end
        check_counts("rst_mid");
        idle(3);
        send_frame(16'h5BA9, 1'b1);
        idle(2);
        check_counts("rst_recover");
    endtask

    task automatic test_broadcast();
`ifdef RX_BROADCAST_EN
        send_frame(16'h5FA3, 1'b1);
`else
        send_frame(16'h5FA3, 1'b0);
`endif
        idle(2);
        check_counts("broadcast");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 300; k++) send_frame(16'h5BA7, 1'b1);
        idle(2);
        checks++;
        if (bus.rx_ok_count !== 8'hFF) begin
            errors++;
            $display("FAIL sat_ok_count got=%h exp=ff", bus.rx_ok_count);
        end
        check_counts("sat");
    endtask

    task automatic test_stuck_high();
        bit seen_busy;
        int n0;
        seen_busy = 1'b0;
        n0 = vld_cyc_q.size();
        for (int i = 0; i < 100; i++) begin
            drive_bit(1'b1);
            if (bus.rx_busy !== 1'b0) seen_busy = 1'b1;
        end
        bus.rx_bit = 1'b0;
        checks++;
        if (seen_busy) begin
            errors++;
            $display("FAIL stuck_high_busy got=1 exp=0");
        end
        checks++;
        if (vld_cyc_q.size() != n0) begin
            errors++;
            $display("FAIL stuck_high_valid got=%0d pulses exp=0", vld_cyc_q.size() - n0);
        end
        idle(2);
        check_counts("stuck_high");
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_bit = 1'b0;
        bus.abort = 1'b0;
        exp_ok = 8'd0;
        exp_drop = 8'd0;
        test_reset();
        test_accept();
        test_filter();
        test_back_to_back();
        test_abort();
        test_rst_mid();
        test_broadcast();
        test_saturation();
        test_stuck_high();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
